down_count_tracker: RTL and testbench
=====================================

Name: down_count_tracker

Overview:
- Sits directly downstream of the 4-bit synchronous down counter and consumes its q output on the same clk.
- Checks that every sampled value is either a hold or a decrement by exactly 1 (modulo 2^WIDTH).
- Produces a one-cycle terminal-count pulse on each wrap (0 -> all-ones) and a saturating wrap ("epoch") tally.
- Raises a sticky error on any illegal step; the downstream status/display logic reads these outputs.

Parameters:
WIDTH, 4, width of the monitored counter value
EPOCH_W, 8, width of the wrap tally

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
clr  input  1  synchronous clear of tally, error and tracking state; active-high
q_in  input  WIDTH  counter value from the down counter
tc  output  1  one-cycle pulse, registered, one cycle after a wrap is sampled
epoch  output  EPOCH_W  number of wraps seen; saturates at all-ones
held  output  1  registered; 1 when the last sampled q_in equalled the previous sample
step_err  output  1  sticky; set on the first illegal step
busy  output  1  1 in TRACK or ERROR (a reference sample is held)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, q_prev=0, tc=0, epoch=0, held=0, step_err=0, busy=0.
  - Takes effect immediately, including mid-sequence.
  - Release is sampled on the next rising clk.
- State IDLE:
  - Next edge: q_prev<=q_in, state<=TRACK, busy<=1.
  - No step check is made, so tc=0 and held=0 in the following cycle.
- State TRACK: each edge, q_in is classified against q_prev:
  - HOLD: q_in==q_prev. held<=1, tc<=0.
  - DEC: q_prev!=0 and q_in==q_prev-1. held<=0, tc<=0.
  - WRAP: q_prev==0 and q_in=={WIDTH{1}}. held<=0, tc<=1.
    - epoch<=epoch+1 unless epoch=={EPOCH_W{1}}; then it holds (saturates, no wrap).
  - BAD (anything else):
    - step_err<=1, state<=ERROR, tc<=0, held<=0.
    - epoch is frozen from this cycle on.
  - q_prev<=q_in in all cases.
- State ERROR:
  - q_prev keeps updating.
  - tc stays 0, epoch is frozen, step_err stays 1, held stays 0.
  - The only exits are clr or reset.
- tc: high for exactly one cycle per WRAP. Back-to-back wraps are impossible with a legal counter.
- clr=1 (synchronous) has priority over all classification:
  - Next edge: state<=IDLE, tc<=0, epoch<=0, held<=0, step_err<=0, busy<=0.
  - q_in on that edge is ignored; the edge after clr deasserts re-samples the reference.
- All outputs are registered; there is no combinational path from q_in to any output.
- Arithmetic:
  - q_prev-1 is computed in WIDTH bits.
  - The WRAP test is explicit and does not rely on unsigned wrap.

Decomposition:
- Package dct_pkg:
  - state enum IDLE=2'd0, TRACK=2'd1, ERROR=2'd2.
  - step-class enum HOLD, DEC, WRAP, BAD.
  - Default width constants.
- Sub-module dct_step_classify: purely combinational; inputs q_prev and q_in; output step class.
- The top holds the FSM, registers and epoch saturation.

Test Plan:
1. Reset low for 10 ns, then high; q_in sequence 3,2,1,0,15,14 -> busy=1 after the first edge; tc=1 for one cycle after 15 is sampled; epoch=1; step_err=0.
2. q_in sequence 5,5,5,4 -> held=1 for two cycles, then 0; no tc; step_err=0.
3. q_in sequence 7,6,2 -> step_err=1 after 2 is sampled; then 1,0,15 -> tc stays 0, epoch stays unchanged.
4. Apply clr=1 for one cycle in ERROR -> step_err=0, epoch=0, busy=0; next edge re-samples; the following 9,8 is legal.
5. EPOCH_W=2, run 5 full wraps -> epoch reads 3 after the 3rd wrap and stays 3; tc still pulses on each wrap.
6. Drive reset=0 mid-cycle while tc=1 and epoch=2 -> all outputs 0 immediately, without waiting for clk; after release, the first sample raises no error.

Source files
------------

// File: rtl/down_count_tracker_pkg.sv
// Shared types and default widths for the down-counter tracker.
package dct_pkg;

    localparam int unsigned DCT_WIDTH   = 4;
    localparam int unsigned DCT_EPOCH_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        HOLD,
        DEC,
        WRAP,
        BAD
    } step_e;

endpackage

// File: rtl/down_count_tracker_if.sv
// Counter sample in, tracker status out; clk and reset stay outside.
interface down_count_tracker_if
    import dct_pkg::*;
#(
    parameter int unsigned WIDTH   = DCT_WIDTH,
    parameter int unsigned EPOCH_W = DCT_EPOCH_W
);
    logic               clr;
    logic [WIDTH-1:0]   q_in;
    logic               tc;
    logic [EPOCH_W-1:0] epoch;
    logic               held;
    logic               step_err;
    logic               busy;

    modport master (
        output clr, q_in,
        input  tc, epoch, held, step_err, busy
    );

    modport slave (
        input  clr, q_in,
        output tc, epoch, held, step_err, busy
    );
endinterface

// File: rtl/down_count_tracker_step_classify.sv
// Classifies one counter step (previous sample -> current sample).
module dct_step_classify
    import dct_pkg::*;
#(
    parameter int unsigned WIDTH = DCT_WIDTH
) (
    input  logic [WIDTH-1:0] q_prev,
    input  logic [WIDTH-1:0] q_in,
    output step_e            step
);
    logic [WIDTH-1:0] q_dec;

    assign q_dec = q_prev - WIDTH'(1);

    // Wrap is tested explicitly, so the decrement never relies on 0-1 wrapping.
    always_comb begin
        step = BAD;
        if (q_in == q_prev) begin
            step = HOLD;
        end else if ((q_prev != '0) && (q_in == q_dec)) begin
            step = DEC;
        end else if ((q_prev == '0) && (q_in == '1)) begin
            step = WRAP;
        end
    end
endmodule

// File: rtl/down_count_tracker.sv
// Monitors a down counter: hold/decrement legality, wrap pulse and saturating wrap tally.
module down_count_tracker
    import dct_pkg::*;
#(
    parameter int unsigned WIDTH   = DCT_WIDTH,
    parameter int unsigned EPOCH_W = DCT_EPOCH_W
) (
    input  logic                 clk,
    input  logic                 reset,
    down_count_tracker_if.slave  bus
);
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   q_prev_q, q_prev_d;
    logic               tc_q, tc_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               held_q, held_d;
    logic               err_q, err_d;
    step_e              step;

    dct_step_classify #(.WIDTH(WIDTH)) u_classify (
        .q_prev (q_prev_q),
        .q_in   (bus.q_in),
        .step   (step)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            q_prev_q <= '0;
            tc_q     <= 1'b0;
            epoch_q  <= '0;
            held_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_prev_q <= q_prev_d;
            tc_q     <= tc_d;
            epoch_q  <= epoch_d;
            held_q   <= held_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        q_prev_d = q_prev_q;
        tc_d     = 1'b0;
        held_d   = 1'b0;
        epoch_d  = epoch_q;
        err_d    = err_q;
        if (bus.clr) begin
            state_d = IDLE;
            epoch_d = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    q_prev_d = bus.q_in;
                    state_d  = TRACK;
                end
                TRACK: begin
                    q_prev_d = bus.q_in;
                    case (step)
                        HOLD: held_d = 1'b1;
                        DEC:  ;
                        WRAP: begin
                            tc_d = 1'b1;
                            if (epoch_q != '1) epoch_d = epoch_q + EPOCH_W'(1);
                        end
                        default: begin
                            err_d   = 1'b1;
                            state_d = ERROR;
                        end
                    endcase
                end
                ERROR: q_prev_d = bus.q_in;
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.tc       = tc_q;
    assign bus.epoch    = epoch_q;
    assign bus.held     = held_q;
    assign bus.step_err = err_q;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_down_count_tracker.sv
// Randomized and directed checks of down_count_tracker against a sample-history model.
module tb_down_count_tracker;
    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    logic clk;
    logic reset;

    down_count_tracker_if #(.WIDTH(W), .EPOCH_W(8)) bus8 ();
    down_count_tracker_if #(.WIDTH(W), .EPOCH_W(2)) bus2 ();

    down_count_tracker #(.WIDTH(W), .EPOCH_W(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
    down_count_tracker #(.WIDTH(W), .EPOCH_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: whether a reference sample exists, its value, and what has happened since.
    bit m_have, m_err, m_tc, m_held;
    int m_prev, m_wraps;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_have = 0; m_err = 0; m_tc = 0; m_held = 0; m_prev = 0; m_wraps = 0;
    endtask

    task automatic model_edge(input int q, input bit c);
        m_tc   = 0;
        m_held = 0;
        if (c) begin
            m_have  = 0;
            m_err   = 0;
            m_wraps = 0;
        end else if (!m_have) begin
            m_have = 1;
            m_prev = q;
        end else begin
            if (!m_err) begin
                if (q == m_prev)                              m_held = 1;
                else if (m_prev != 0 && q == m_prev - 1)      m_held = 0;
                else if (m_prev == 0 && q == MASK) begin
                    m_tc = 1;
                    m_wraps++;
                end else                                      m_err = 1;
            end
            m_prev = q;
        end
    endtask

    task automatic check_all();
        int e8, e2;
        e8 = (m_wraps > 255) ? 255 : m_wraps;
        e2 = (m_wraps > 3) ? 3 : m_wraps;
        check("tc8",    int'(bus8.tc),       int'(m_tc));
        check("held8",  int'(bus8.held),     int'(m_held));
        check("err8",   int'(bus8.step_err), int'(m_err));
        check("busy8",  int'(bus8.busy),     int'(m_have));
        check("epoch8", int'(bus8.epoch),    e8);
        check("tc2",    int'(bus2.tc),       int'(m_tc));
        check("held2",  int'(bus2.held),     int'(m_held));
        check("err2",   int'(bus2.step_err), int'(m_err));
        check("busy2",  int'(bus2.busy),     int'(m_have));
        check("epoch2", int'(bus2.epoch),    e2);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic drive(input int q, input bit c);
        bus8.q_in = W'(q); bus2.q_in = W'(q);
        bus8.clr  = c;     bus2.clr  = c;
        @(posedge clk);
        model_edge(q, c);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic drive_seq(input int vals[]);
        foreach (vals[i]) drive(vals[i], 1'b0);
    endtask

    initial begin
        int cur, r;
        reset = 1'b0;
        bus8.q_in = '0; bus2.q_in = '0;
        bus8.clr = 1'b0; bus2.clr = 1'b0;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        reset = 1'b1;

        drive_seq('{3, 2, 1, 0, 15, 14});
        drive(0, 1'b1);
        drive_seq('{5, 5, 5, 4});
        drive(0, 1'b1);
        drive_seq('{7, 6, 2, 1, 0, 15});
        drive(0, 1'b1);
        drive_seq('{9, 8});

        drive(0, 1'b1);
        for (int n = 0; n < 5 * 16 + 1; n++) drive((15 - (n % 16)), 1'b0);

        // Asynchronous reset while tc is high with two wraps tallied.
        drive(0, 1'b1);
        drive_seq('{1, 0, 15});
        for (int v = 14; v >= 0; v--) drive(v, 1'b0);
        drive(15, 1'b0);
        check("pre_rst_tc", int'(bus8.tc), 1);
        check("pre_rst_epoch", int'(bus8.epoch), 2);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b1;
        drive_seq('{10, 9, 9, 8});

        cur = 12;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(99);
            if (r < 30) begin
                drive(cur, 1'b0);
            end else if (r < 93) begin
                cur = (cur - 1) & MASK;
                drive(cur, 1'b0);
            end else if (r < 96) begin
                cur = $urandom_range(MASK);
                drive(cur, 1'b0);
            end else begin
                drive(cur, 1'b1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1, "timeout");
    end
endmodule
